// File: rtl/demorgan_vec_checker_if.sv
// demorgan_vec_checker_if: stimulus/response bundle between the checker and its lab harness
interface demorgan_vec_checker_if #(
    parameter int N_IN  = 2,
    parameter int CNT_W = 8
);
    logic             start;
    logic             dut_e;
    logic [N_IN-1:0]  vec;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_cnt;
    logic [N_IN-1:0]  first_fail;
    modport master (output start, dut_e, input vec, busy, done, pass, err_cnt, first_fail);
    modport slave  (input start, dut_e, output vec, busy, done, pass, err_cnt, first_fail);
endinterface

// File: rtl/demorgan_vec_checker.sv
// demorgan_vec_checker: walks every input vector through a NOR gate under test and tallies mismatches
module demorgan_vec_checker #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 2,
    parameter int CNT_W  = 8
) (
    input logic                   clk,
    input logic                   rst_n,
    demorgan_vec_checker_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;
    localparam int SW = SETTLE > 1 ? $clog2(SETTLE) : 1;

    logic [1:0]       state;
    logic [SW-1:0]    cnt;
    logic [N_IN-1:0]  vec;
    logic [N_IN-1:0]  first_fail;
    logic [CNT_W-1:0] err_cnt;
    logic             failed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            vec        <= '0;
            first_fail <= '0;
            err_cnt    <= '0;
            failed     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: if (bus.start) begin
                    state      <= WAIT;
                    cnt        <= '0;
                    vec        <= '0;
                    first_fail <= '0;
                    err_cnt    <= '0;
                    failed     <= 1'b0;
                end
                WAIT: if (cnt == SW'(SETTLE - 1)) state <= CHECK;
                      else cnt <= cnt + 1'b1;
                CHECK: begin
                    if (bus.dut_e != ~|vec) begin
                        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
                        if (!failed) begin
                            failed     <= 1'b1;
                            first_fail <= vec;
                        end
                    end
                    if (&vec) state <= DONE;
                    else begin
                        state <= WAIT;
                        vec   <= vec + 1'b1;
                        cnt   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // status decoded from state so an async reset clears it without waiting for an edge
    assign bus.vec        = vec;
    assign bus.busy       = (state == WAIT) || (state == CHECK);
    assign bus.done       = state == DONE;
    assign bus.pass       = (state == DONE) && (err_cnt == '0);
    assign bus.err_cnt    = err_cnt;
    assign bus.first_fail = first_fail;
endmodule

// File: tb/tb_demorgan_vec_checker.sv
// tb_demorgan_vec_checker: drives truth-table gates into two checker configurations and scores results
module tb_demorgan_vec_checker;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] tt_a = 4'b0001;
    logic [7:0] tt_b = 8'b0000_0001;
    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    demorgan_vec_checker_if #(.N_IN(2), .CNT_W(8)) a ();
    demorgan_vec_checker_if #(.N_IN(3), .CNT_W(2)) b ();

    assign a.dut_e = tt_a[a.vec];
    assign b.dut_e = tt_b[b.vec];

    demorgan_vec_checker #(.N_IN(2), .SETTLE(2), .CNT_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a.slave));
    demorgan_vec_checker #(.N_IN(3), .SETTLE(2), .CNT_W(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b.slave));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // start is driven in cycle 0 and sampled at edge 1; c counts edges since then
    task automatic run_a(input logic [3:0] t, input bit poke);
        int ne = 0, ff = 0, c = 1;
        tt_a = t;
        a.start = 1'b1;
        @(negedge clk);
        a.start = 1'b0;
        check("a_clr_done", a.done, 0);
        check("a_clr_err", a.err_cnt, 0);
        check("a_clr_ff", a.first_fail, 0);
        while (!a.done && c < 40) begin
            check("a_busy", a.busy, 1);
            check("a_vec", a.vec, (c - 1) / 3);
            a.start = poke && c == 5;
            @(negedge clk);
            c++;
        end
        a.start = 1'b0;
        check("a_done_cycle", c, 13);
        for (int v = 0; v < 4; v++)
            if (t[v] !== (v == 0)) begin
                if (ne == 0) ff = v;
                ne++;
            end
        check("a_err_cnt", a.err_cnt, ne);
        check("a_first_fail", a.first_fail, ff);
        check("a_pass", a.pass, ne == 0);
        check("a_busy_end", a.busy, 0);
    endtask

    task automatic run_b(input logic [7:0] t);
        int ne = 0, ff = 0, c = 1;
        tt_b = t;
        b.start = 1'b1;
        @(negedge clk);
        b.start = 1'b0;
        while (!b.done && c < 80) begin
            check("b_vec", b.vec, (c - 1) / 3);
            @(negedge clk);
            c++;
        end
        check("b_done_cycle", c, 25);
        for (int v = 0; v < 8; v++)
            if (t[v] !== (v == 0)) begin
                if (ne == 0) ff = v;
                ne++;
            end
        check("b_err_cnt", b.err_cnt, ne > 3 ? 3 : ne);
        check("b_first_fail", b.first_fail, ff);
        check("b_pass", b.pass, ne == 0);
    endtask

    initial begin
        a.start = 1'b0;
        b.start = 1'b0;
        #2;
        check("rst_busy", a.busy, 0);
        check("rst_done", a.done, 0);
        check("rst_pass", a.pass, 0);
        check("rst_vec", a.vec, 0);
        check("rst_err", a.err_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", a.busy, 0);
        run_a(4'b0001, 1'b0);
        run_a(4'b0000, 1'b0);
        run_a(4'b0111, 1'b0);
        run_a(4'b0001, 1'b1);
        run_a(4'b0111, 1'b1);
        for (int i = 0; i < 6; i++) run_a(4'($urandom), 1'b0);
        // reset in the CHECK cycle of vec=2, after vec=1 already failed
        tt_a = 4'b0111;
        a.start = 1'b1;
        @(negedge clk);
        a.start = 1'b0;
        repeat (8) @(negedge clk);
        check("mid_vec", a.vec, 2);
        check("mid_err", a.err_cnt, 1);
        rst_n = 1'b0;
        #1;
        check("arst_busy", a.busy, 0);
        check("arst_done", a.done, 0);
        check("arst_vec", a.vec, 0);
        check("arst_err", a.err_cnt, 0);
        check("arst_ff", a.first_fail, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_busy", a.busy, 0);
        check("post_done", a.done, 0);
        check("post_vec", a.vec, 0);
        run_a(4'b0001, 1'b0);
        run_b(8'b1111_1110);
        run_b(8'b0000_0001);
        for (int i = 0; i < 3; i++) run_b(8'($urandom));
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
